// File: rtl/crossing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crossing_pkg
// Purpose  : Shared state encoding, default parameters and counter sizing
//            for the level-crossing sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package crossing_pkg;

    localparam int N_TRACKS_DEF     = 4;
    localparam int WARN_CYCLES_DEF  = 64;
    localparam int HOLD_CYCLES_DEF  = 32;
    localparam int MOVE_TIMEOUT_DEF = 256;
    localparam int FLASH_HALF_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WARN     = 3'd1,
        ST_LOWERING = 3'd2,
        ST_CLOSED   = 3'd3,
        ST_RAISING  = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    // Width of the shared down-counter: enough for the largest cycle count, plus one.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/track_occupancy.sv
`default_nettype none
// ============================================================================
// Module   : track_occupancy
// Purpose  : Per-track sensor edge detection and occupancy flag.
// Revision : 1.0 - initial release
// ============================================================================
module track_occupancy
    import crossing_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic approach,
    input  logic exit_s,
    output logic occupied
);

    logic approach_q;
    logic exit_q;
    logic approach_ev;
    logic exit_ev;

    // Events are registered before they touch the flag, giving two cycles of latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            approach_q  <= 1'b0;
            exit_q      <= 1'b0;
            approach_ev <= 1'b0;
            exit_ev     <= 1'b0;
            occupied    <= 1'b0;
        end else begin
            approach_q  <= approach;
            exit_q      <= exit_s;
            approach_ev <= approach & ~approach_q;
            exit_ev     <= exit_s & ~exit_q;
            occupied    <= (occupied & ~exit_ev) | approach_ev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/crossing_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : crossing_sequencer
// Purpose  : Multi-track level-crossing warn/lower/hold/raise sequencer.
//            Optional macro CROSSING_FLASH_EN enables lamp flashing.
// Revision : 1.0 - initial release
// ============================================================================
module crossing_sequencer
    import crossing_pkg::*;
#(
    parameter int N_TRACKS     = N_TRACKS_DEF,
    parameter int WARN_CYCLES  = WARN_CYCLES_DEF,
    parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int MOVE_TIMEOUT = MOVE_TIMEOUT_DEF,
    parameter int FLASH_HALF   = FLASH_HALF_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_TRACKS-1:0] approach,
    input  logic [N_TRACKS-1:0] exit_s,
    input  logic                gate_down_ack,
    input  logic                gate_up_ack,
    input  logic                fault_clr,
    output logic                gate,
    output logic                red_light,
    output logic [N_TRACKS-1:0] occupied,
    output logic                fault
);

    localparam int CW = cnt_width(WARN_CYCLES, HOLD_CYCLES, MOVE_TIMEOUT, FLASH_HALF);
    localparam logic [CW-1:0] WARN_LOAD = CW'(WARN_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] MOVE_LOAD = CW'(MOVE_TIMEOUT - 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            any_occ;
    logic            gate_next;
    logic            fault_next;
    logic            red_next;
    logic            lamp_active_next;
    logic            lamp_level;

    generate
        for (genvar i = 0; i < N_TRACKS; i++) begin : g_track
            track_occupancy u_track (
                .clk      (clk),
                .reset_n  (reset_n),
                .approach (approach[i]),
                .exit_s   (exit_s[i]),
                .occupied (occupied[i])
            );
        end
    endgenerate

    assign any_occ = |occupied;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = (cnt == '0) ? '0 : cnt - 1'b1;
        case (state)
            ST_IDLE: begin
                if (any_occ) state_next = ST_WARN;
            end
            ST_WARN: begin
                if (cnt == '0) state_next = ST_LOWERING;
            end
            ST_LOWERING: begin
                if (gate_down_ack)   state_next = ST_CLOSED;
                else if (cnt == '0)  state_next = ST_FAULT;
            end
            ST_CLOSED: begin
                if (any_occ)         cnt_next   = HOLD_LOAD;
                else if (cnt == '0)  state_next = ST_RAISING;
            end
            ST_RAISING: begin
                if (any_occ)          state_next = ST_LOWERING;
                else if (gate_up_ack) state_next = ST_IDLE;
                else if (cnt == '0)   state_next = ST_FAULT;
            end
            ST_FAULT: begin
                if (fault_clr && !any_occ) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Every state entry reloads the shared timer for the new state.
        if (state_next != state) begin
            case (state_next)
                ST_WARN:     cnt_next = WARN_LOAD;
                ST_LOWERING: cnt_next = MOVE_LOAD;
                ST_CLOSED:   cnt_next = HOLD_LOAD;
                ST_RAISING:  cnt_next = MOVE_LOAD;
                default:     cnt_next = '0;
            endcase
        end
    end

`ifdef CROSSING_FLASH_EN
    localparam int FW = $clog2(FLASH_HALF) + 1;
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_HALF - 1);

    logic [FW-1:0] flash_cnt;
    logic [FW-1:0] flash_cnt_next;
    logic          flash_phase;
    logic          flash_phase_next;

    always_comb begin
        flash_cnt_next   = flash_cnt - 1'b1;
        flash_phase_next = flash_phase;
        if ((state_next == ST_WARN) && (state != ST_WARN)) begin
            flash_cnt_next   = FLASH_LOAD;
            flash_phase_next = 1'b1;
        end else if (flash_cnt == '0) begin
            flash_cnt_next   = FLASH_LOAD;
            flash_phase_next = ~flash_phase;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
        end else begin
            flash_cnt   <= flash_cnt_next;
            flash_phase <= flash_phase_next;
        end
    end

    assign lamp_level = flash_phase_next;
`else
    assign lamp_level = 1'b1;
`endif

    // Outputs are decoded from the next state so they change on the entry edge.
    always_comb begin
        lamp_active_next = (state_next == ST_WARN)   || (state_next == ST_LOWERING) ||
                           (state_next == ST_CLOSED) || (state_next == ST_RAISING);
        gate_next        = (state_next == ST_LOWERING) || (state_next == ST_CLOSED) ||
                           (state_next == ST_FAULT);
        fault_next       = (state_next == ST_FAULT);
        red_next         = lamp_active_next ? lamp_level : fault_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate      <= 1'b0;
            red_light <= 1'b0;
            fault     <= 1'b0;
        end else begin
            gate      <= gate_next;
            red_light <= red_next;
            fault     <= fault_next;
        end
    end

endmodule
`default_nettype wire
